// File: rtl/vend_pkg.sv
// Shared coin encodings, coin valuation and the sequencer state type.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam int COIN_VAL_W = 5;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} vend_state_t;

  // Credit value of a coin code; COIN_NONE is worth nothing.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    logic [COIN_VAL_W-1:0] v;
    case (code)
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      COIN_20: v = 5'd20;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable up-counter with clear and enable; tc_o flags the terminal count MAX-1.
module vend_timer #(
  parameter int MAX = 1000,
  parameter int W   = $clog2(MAX) + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over load, load wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: credit accumulation, vend handshake and
// coin-by-coin change/refund over a req/ack link to the coin hopper.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE   = 15,
  parameter int BAL_W   = 7,
  parameter int MAX_BAL = 127,
  parameter int IDLE_TO = 1000,
  parameter int ACK_TO  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_valid,
  input  logic [1:0]       coin_code,
  input  logic             cancel,
  output logic             coin_reject,
  output logic             vend_req,
  input  logic             vend_ack,
  output logic             chg_req,
  output logic [1:0]       chg_code,
  input  logic             chg_ack,
  output logic [BAL_W-1:0] balance,
  output logic             dispense,
  output logic             fault,
  output logic             busy
);

  vend_state_t      state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic             chg_req_q, chg_req_d;
  logic [1:0]       chg_code_q, chg_code_d;
  logic             vend_req_q, vend_req_d;
  logic             rej_q, rej_d;
  logic             disp_q, disp_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;

  logic             idle_clr, idle_en, idle_tc;
  logic             ack_clr, ack_en, ack_tc;
  logic             coin_ok;
  logic [BAL_W:0]   coin_w, sum;

  // Greedy change selection: largest returnable coin that fits the balance.
  function automatic logic [1:0] change_coin(input logic [BAL_W-1:0] b);
    return (b >= BAL_W'(10)) ? COIN_10 : COIN_5;
  endfunction

  assign coin_ok = coin_valid && (coin_code != COIN_NONE);
  assign coin_w  = (BAL_W+1)'(coin_value(coin_code));
  assign sum     = {1'b0, bal_q} + coin_w;

  vend_timer #(.MAX(IDLE_TO)) u_idle_tmr (
    .clk_i(clk), .rst_i(rst), .clr_i(idle_clr), .en_i(idle_en),
    .load_i(1'b0), .load_val_i('0), .tc_o(idle_tc)
  );

  vend_timer #(.MAX(ACK_TO)) u_ack_tmr (
    .clk_i(clk), .rst_i(rst), .clr_i(ack_clr), .en_i(ack_en),
    .load_i(1'b0), .load_val_i('0), .tc_o(ack_tc)
  );

  // Next-state, balance and registered-output decode; timers clear unless
  // the FSM is actively waiting in the same state.
  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    chg_req_d = 1'b0;
    rej_d     = 1'b0;
    disp_d    = 1'b0;
    fault_d   = fault_q;
    idle_clr  = 1'b1;
    idle_en   = 1'b0;
    ack_clr   = 1'b1;
    ack_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_ok) begin
          bal_d   = BAL_W'(coin_value(coin_code));
          fault_d = 1'b0;
          state_d = CREDIT;
        end else if (cancel && (bal_q != '0)) begin
          // residual credit left by a stuck hopper
          state_d   = CHANGE;
          chg_req_d = 1'b1;
        end
      end
      CREDIT: begin
        if (coin_ok) begin
          if (sum <= (BAL_W+1)'(MAX_BAL)) begin
            bal_d   = sum[BAL_W-1:0];
            fault_d = 1'b0;
          end else begin
            rej_d = 1'b1;
          end
        end
        if (bal_q >= BAL_W'(PRICE)) begin
          state_d = VEND;
        end else if (cancel || idle_tc) begin
          state_d   = CHANGE;
          chg_req_d = 1'b1;
        end else if (!coin_ok) begin
          idle_clr = 1'b0;
          idle_en  = 1'b1;
        end
      end
      VEND: begin
        rej_d = coin_ok;
        if (vend_ack) begin
          bal_d  = bal_q - BAL_W'(PRICE);
          disp_d = 1'b1;
          if (bal_d != '0) begin
            state_d   = CHANGE;
            chg_req_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (ack_tc) begin
          fault_d   = 1'b1;
          state_d   = CHANGE;
          chg_req_d = 1'b1;
        end else begin
          ack_clr = 1'b0;
          ack_en  = 1'b1;
        end
      end
      CHANGE: begin
        rej_d = coin_ok;
        if (chg_req_q) begin
          if (chg_ack) begin
            bal_d = bal_q - BAL_W'(coin_value(chg_code_q));
            if (bal_d == '0) state_d = IDLE;
          end else if (ack_tc) begin
            fault_d = 1'b1;
            state_d = IDLE;
          end else begin
            chg_req_d = 1'b1;
            ack_clr   = 1'b0;
            ack_en    = 1'b1;
          end
        end else begin
          // one idle cycle after each ack, then request the next coin
          chg_req_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    chg_code_d = chg_req_d ? change_coin(bal_d) : COIN_NONE;
    vend_req_d = (state_d == VEND);
    busy_d     = (state_d == VEND) || (state_d == CHANGE);
  end

  // State, balance and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bal_q      <= '0;
      chg_req_q  <= 1'b0;
      chg_code_q <= COIN_NONE;
      vend_req_q <= 1'b0;
      rej_q      <= 1'b0;
      disp_q     <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bal_q      <= bal_d;
      chg_req_q  <= chg_req_d;
      chg_code_q <= chg_code_d;
      vend_req_q <= vend_req_d;
      rej_q      <= rej_d;
      disp_q     <= disp_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

  assign coin_reject = rej_q;
  assign vend_req    = vend_req_q;
  assign chg_req     = chg_req_q;
  assign chg_code    = chg_code_q;
  assign balance     = bal_q;
  assign dispense    = disp_q;
  assign fault       = fault_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed scenarios plus randomized
// purchase/refund transactions checked against an arithmetic credit model.
module tb_vend_txn_ctrl;

  localparam int PRICE   = 15;
  localparam int BAL_W   = 7;
  localparam int MAX_BAL = 25;
  localparam int IDLE_TO = 20;
  localparam int ACK_TO  = 8;

  logic             clk;
  logic             rst;
  logic             coin_valid;
  logic [1:0]       coin_code;
  logic             cancel;
  logic             coin_reject;
  logic             vend_req;
  logic             vend_ack;
  logic             chg_req;
  logic [1:0]       chg_code;
  logic             chg_ack;
  logic [BAL_W-1:0] balance;
  logic             dispense;
  logic             fault;
  logic             busy;

  int n_tests;
  int n_fail;
  int cnt;

  vend_txn_ctrl #(
    .PRICE(PRICE), .BAL_W(BAL_W), .MAX_BAL(MAX_BAL),
    .IDLE_TO(IDLE_TO), .ACK_TO(ACK_TO)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_code(coin_code),
    .cancel(cancel), .coin_reject(coin_reject), .vend_req(vend_req),
    .vend_ack(vend_ack), .chg_req(chg_req), .chg_code(chg_code),
    .chg_ack(chg_ack), .balance(balance), .dispense(dispense),
    .fault(fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Credit value of a coin code, from the coin table.
  function automatic int cval(input int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 20;
      default: return 0;
    endcase
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_code  = code;
    step();
    coin_valid = 1'b0;
    coin_code  = 2'b00;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? vend_req : chg_req;
  endfunction

  task automatic wait_sig(input string tag, input int sel, input int lim);
    int n;
    n = 0;
    while (!sig(sel) && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(sig(sel)), 1);
  endtask

  // Expect the hopper to pay out 'amount' greedily, one acked coin at a time.
  task automatic service_change(input int amount, input bit force_stray);
    int rem;
    int exp_code;
    rem = amount;
    while (rem > 0) begin
      exp_code = (rem >= 10) ? 2 : 1;
      wait_sig("chg_req_rise", 1, 4);
      chk("chg_code", 32'(chg_code), exp_code);
      chk("busy_chg", 32'(busy), 1);
      if (force_stray || $urandom_range(0, 3) == 0) begin
        force_stray = 1'b0;
        coin(2'($urandom_range(1, 3)));
        chk("rej_in_chg", 32'(coin_reject), 1);
        chk("bal_hold_chg", 32'(balance), rem);
      end
      repeat ($urandom_range(0, 2)) step();
      chk("chg_req_held", 32'(chg_req), 1);
      chg_ack = 1'b1;
      step();
      chg_ack = 1'b0;
      rem -= (exp_code == 2) ? 10 : 5;
      chk("bal_after_chg", 32'(balance), rem);
      chk("chg_req_drop", 32'(chg_req), 0);
    end
    chk("busy_done", 32'(busy), 0);
    chk("bal_zero", 32'(balance), 0);
  endtask

  // Called right after the coin that brought credit to PRICE or above.
  task automatic do_vend(input int bal, input int d, input bit stray);
    int rem;
    chk("vreq_lat0", 32'(vend_req), 0);
    step();
    chk("vreq_lat1", 32'(vend_req), 1);
    chk("busy_vend", 32'(busy), 1);
    for (int i = 0; i < d; i++) begin
      if (i == 0 && stray) begin
        coin(2'b11);
        chk("rej_in_vend", 32'(coin_reject), 1);
        chk("bal_hold_vend", 32'(balance), bal);
      end else begin
        step();
      end
    end
    chk("vreq_held", 32'(vend_req), 1);
    vend_ack = 1'b1;
    step();
    vend_ack = 1'b0;
    rem = bal - PRICE;
    chk("dispense", 32'(dispense), 1);
    chk("bal_vended", 32'(balance), rem);
    chk("vreq_drop", 32'(vend_req), 0);
    step();
    chk("dispense_pulse", 32'(dispense), 0);
    if (rem > 0) begin
      service_change(rem, 1'b0);
    end else begin
      chk("chg_none", 32'(chg_req), 0);
      chk("busy_idle", 32'(busy), 0);
    end
  endtask

  task automatic rand_vend();
    int bal;
    int c;
    int v;
    int guard;
    bal   = 0;
    guard = 0;
    while (bal < PRICE && guard < 10) begin
      c = $urandom_range(1, 3);
      v = cval(c);
      coin(2'(c));
      if (bal + v > MAX_BAL) begin
        chk("rej_ovf", 32'(coin_reject), 1);
      end else begin
        bal += v;
        chk("rej_none", 32'(coin_reject), 0);
      end
      chk("bal_acc", 32'(balance), bal);
      if (bal < PRICE) repeat ($urandom_range(0, 3)) step();
      guard++;
    end
    do_vend(bal, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
  endtask

  task automatic rand_cancel();
    int bal;
    int c;
    c = $urandom_range(1, 2);
    coin(2'(c));
    bal = cval(c);
    chk("rc_bal", 32'(balance), bal);
    if (bal == 5 && $urandom_range(0, 1) == 1) begin
      coin(2'b01);
      bal = 10;
      chk("rc_bal2", 32'(balance), bal);
    end
    repeat ($urandom_range(0, 3)) step();
    if ($urandom_range(0, 1) == 1) begin
      coin_valid = 1'b1;
      coin_code  = 2'b01;
      cancel     = 1'b1;
      step();
      coin_valid = 1'b0;
      coin_code  = 2'b00;
      cancel     = 1'b0;
      bal += 5;
    end else begin
      pulse_cancel();
    end
    chk("rc_bal_refund", 32'(balance), bal);
    chk("rc_chg_req", 32'(chg_req), 1);
    chk("rc_no_vend", 32'(vend_req), 0);
    service_change(bal, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    coin_valid = 1'b0;
    coin_code  = 2'b00;
    cancel     = 1'b0;
    vend_ack   = 1'b0;
    chg_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_balance", 32'(balance), 0);
    chk("rst_vend_req", 32'(vend_req), 0);
    chk("rst_chg_req", 32'(chg_req), 0);
    chk("rst_chg_code", 32'(chg_code), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_dispense", 32'(dispense), 0);
    chk("rst_reject", 32'(coin_reject), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // code 00 ignored, cancel and stray acks in IDLE have no effect
    coin(2'b00);
    chk("nocoin_rej", 32'(coin_reject), 0);
    chk("nocoin_bal", 32'(balance), 0);
    chk("nocoin_busy", 32'(busy), 0);
    pulse_cancel();
    chk("idle_cancel_chg", 32'(chg_req), 0);
    chk("idle_cancel_busy", 32'(busy), 0);
    vend_ack = 1'b1;
    chg_ack  = 1'b1;
    step();
    vend_ack = 1'b0;
    chg_ack  = 1'b0;
    chk("stray_disp", 32'(dispense), 0);
    chk("stray_bal", 32'(balance), 0);

    // 5 + 10, ack after 3 cycles, exact price
    coin(2'b01);
    chk("t1_bal5", 32'(balance), 5);
    coin(2'b10);
    chk("t1_bal15", 32'(balance), 15);
    do_vend(15, 3, 1'b0);

    // 20 -> vend, change 5
    coin(2'b11);
    chk("t2_bal20", 32'(balance), 20);
    do_vend(20, 1, 1'b0);

    // 5,5 then 20 overflows MAX_BAL and is rejected, then 10 -> vend, change 5
    coin(2'b01);
    coin(2'b01);
    chk("t3_bal10", 32'(balance), 10);
    coin(2'b11);
    chk("t3_rej", 32'(coin_reject), 1);
    chk("t3_bal_kept", 32'(balance), 10);
    step();
    chk("t3_rej_pulse", 32'(coin_reject), 0);
    coin(2'b10);
    chk("t3_bal20", 32'(balance), 20);
    do_vend(20, 2, 1'b1);

    // 5 + 20 lands exactly on MAX_BAL and is accepted, change 10
    coin(2'b01);
    coin(2'b11);
    chk("max_rej", 32'(coin_reject), 0);
    chk("max_bal", 32'(balance), 25);
    do_vend(25, 0, 1'b0);

    // 10 then cancel: one 10 coin back, stray coin rejected during change
    coin(2'b10);
    pulse_cancel();
    chk("t4_chg_req", 32'(chg_req), 1);
    chk("t4_no_vend", 32'(vend_req), 0);
    service_change(10, 1'b1);

    // coin and cancel together: coin counted, refund of 15 as 10 then 5
    coin(2'b10);
    coin_valid = 1'b1;
    coin_code  = 2'b01;
    cancel     = 1'b1;
    step();
    coin_valid = 1'b0;
    coin_code  = 2'b00;
    cancel     = 1'b0;
    chk("cc_bal", 32'(balance), 15);
    chk("cc_chg_req", 32'(chg_req), 1);
    chk("cc_no_vend", 32'(vend_req), 0);
    service_change(15, 1'b0);

    // inactivity timeout refund
    coin(2'b01);
    repeat (IDLE_TO - 1) step();
    chk("idle_to_early", 32'(chg_req), 0);
    step();
    chk("idle_to_chg", 32'(chg_req), 1);
    chk("idle_to_code", 32'(chg_code), 1);
    service_change(5, 1'b0);

    // vend ack timeout: fault, full refund, next coin clears fault
    coin(2'b01);
    coin(2'b10);
    step();
    chk("vto_vreq", 32'(vend_req), 1);
    chk("vto_fault0", 32'(fault), 0);
    cnt = 0;
    while (vend_req && cnt < 20) begin
      step();
      cnt++;
    end
    chk("vto_cycles", cnt, ACK_TO);
    chk("vto_fault", 32'(fault), 1);
    chk("vto_chg_req", 32'(chg_req), 1);
    chk("vto_bal", 32'(balance), 15);
    chk("vto_no_disp", 32'(dispense), 0);
    service_change(15, 1'b0);
    chk("fault_sticky", 32'(fault), 1);
    coin(2'b01);
    chk("fault_clr", 32'(fault), 0);
    chk("fault_clr_bal", 32'(balance), 5);
    pulse_cancel();
    service_change(5, 1'b0);

    // stuck hopper: fault, credit retained in IDLE, refunded on next cancel
    coin(2'b10);
    pulse_cancel();
    chk("sh_chg_req", 32'(chg_req), 1);
    cnt = 0;
    while (chg_req && cnt < 20) begin
      step();
      cnt++;
    end
    chk("sh_cycles", cnt, ACK_TO);
    chk("sh_fault", 32'(fault), 1);
    chk("sh_busy", 32'(busy), 0);
    chk("sh_bal", 32'(balance), 10);
    pulse_cancel();
    chk("sh_refund_req", 32'(chg_req), 1);
    service_change(10, 1'b0);
    chk("sh_fault_kept", 32'(fault), 1);
    coin(2'b01);
    chk("sh_fault_clr", 32'(fault), 0);
    pulse_cancel();
    service_change(5, 1'b0);

    // asynchronous reset in the middle of a change payout
    coin(2'b10);
    pulse_cancel();
    chk("ar_chg_req", 32'(chg_req), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_chg_req0", 32'(chg_req), 0);
    chk("ar_bal0", 32'(balance), 0);
    chk("ar_busy0", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ar_idle_busy", 32'(busy), 0);
    chk("ar_idle_chg", 32'(chg_req), 0);
    coin(2'b01);
    chk("ar_post_bal", 32'(balance), 5);
    chk("ar_post_busy", 32'(busy), 0);
    pulse_cancel();
    service_change(5, 1'b0);

    // randomized purchases and refunds
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 2) rand_cancel();
      else                           rand_vend();
      if ($urandom_range(0, 3) == 0) begin
        vend_ack = 1'b1;
        chg_ack  = 1'b1;
        step();
        vend_ack = 1'b0;
        chg_ack  = 1'b0;
        chk("rnd_stray_disp", 32'(dispense), 0);
        chk("rnd_stray_busy", 32'(busy), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
